// File: rtl/footies_pkg.sv
// Shared definitions for the fighter/hit-resolution slice.
//   - fighter FSM state encodings (IDLE/MOVING/ATTACK/HITSTUN)
//   - screen and character geometry defaults
//   - health / frame / position widths
//   - in_reach(): attack hitbox vs. hurtbox overlap test
package footies_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MOVING  = 3'd1;
  localparam logic [2:0] ST_ATTACK  = 3'd2;
  localparam logic [2:0] ST_HITSTUN = 3'd3;

  localparam int SCREEN_W     = 640;
  localparam int CHAR_W_DEF   = 64;
  localparam int REACH_DEF    = 24;
  localparam int X_W          = $clog2(SCREEN_W);
  localparam int GEOM_W       = X_W + 1;
  localparam int HEALTH_W     = 7;
  localparam int FRAME_W      = 4;

  // Attacker faces the defender; the hitbox spans from the attacker's near
  // edge out to span pixels. The extra bit keeps ax+span from wrapping.
  // Coincident positions are treated as no contact.
  function automatic logic in_reach(input logic [X_W-1:0]    ax,
                                    input logic [X_W-1:0]    dx,
                                    input logic [GEOM_W-1:0] span);
    logic [GEOM_W-1:0] a;
    logic [GEOM_W-1:0] d;
    a = {1'b0, ax};
    d = {1'b0, dx};
    if (a < d)
      return (a + span) > d;
    else if (d < a)
      return (d + span) > a;
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/hit_attack_tracker.sv
// Per-player attack tracker: counts frames of the current attack and
// remembers whether this attack has already connected.
// Ports:
//   clk      in  clock
//   reset_n  in  asynchronous active-low reset
//   state    in  fighter FSM state
//   hold     in  freeze the frame counter (hitstop)
//   landed   in  this player's attack connects on the coming edge
//   active   out attack is on an active frame and has not yet connected
module hit_attack_tracker
  import footies_pkg::*;
#(
  parameter int ACT_START = 1,
  parameter int ACT_END   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] state,
  input  logic       hold,
  input  logic       landed,
  output logic       active
);

  logic [FRAME_W-1:0] frame;
  logic               connected;
  logic               attacking;

  assign attacking = (state == ST_ATTACK);

  // frame reads 0 during the ATTACK entry cycle because it was held at 0
  // while the fighter was in any other state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame     <= '0;
      connected <= 1'b0;
    end else begin
      if (!hold) begin
        if (!attacking)
          frame <= '0;
        else if (frame != {FRAME_W{1'b1}})
          frame <= frame + 1'b1;
      end
      if (!attacking)
        connected <= 1'b0;
      else if (landed)
        connected <= 1'b1;
    end
  end

  assign active = attacking && !connected &&
                  (frame >= FRAME_W'(ACT_START)) &&
                  (frame <= FRAME_W'(ACT_END));

endmodule

// File: rtl/hit_resolver.sv
// Resolves attack hitbox vs. hurtbox overlap between two fighters, pulses
// got_hit back into each fighter FSM, and owns health and KO state.
// Optional feature macro: HITSTOP_EN (adds a freeze counter after each hit).
// Ports:
//   clk         in   fighter FSM clock
//   reset_n     in   asynchronous active-low reset
//   p1_x/p2_x   in   character x positions
//   p1_state/p2_state in fighter FSM states
//   p1_got_hit/p2_got_hit out one-cycle hit pulses
//   p1_health/p2_health   out health
//   p1_ko/p2_ko           out sticky KO flags
//   hitstop     out  freeze active (0 unless HITSTOP_EN)
module hit_resolver
  import footies_pkg::*;
#(
  parameter int CHAR_W     = CHAR_W_DEF,
  parameter int REACH      = REACH_DEF,
  parameter int ACT_START  = 1,
  parameter int ACT_END    = 3,
  parameter int HEALTH_MAX = 100,
  parameter int DAMAGE     = 10
`ifdef HITSTOP_EN
  ,
  parameter int HITSTOP_CYC = 4
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [X_W-1:0]      p1_x,
  input  logic [2:0]          p1_state,
  input  logic [X_W-1:0]      p2_x,
  input  logic [2:0]          p2_state,
  output logic                p1_got_hit,
  output logic                p2_got_hit,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                p1_ko,
  output logic                p2_ko,
  output logic                hitstop
);

  localparam logic [GEOM_W-1:0]   SPAN = GEOM_W'(CHAR_W + REACH);
  localparam logic [HEALTH_W-1:0] DMG  = HEALTH_W'(DAMAGE);
  localparam logic [HEALTH_W-1:0] HMAX = HEALTH_W'(HEALTH_MAX);

  logic p1_active;
  logic p2_active;
  logic hit_p1;
  logic hit_p2;
  logic any_ko;

  function automatic logic [HEALTH_W-1:0] take_damage(input logic [HEALTH_W-1:0] h);
    return (h > DMG) ? (h - DMG) : '0;
  endfunction

  hit_attack_tracker #(
    .ACT_START (ACT_START),
    .ACT_END   (ACT_END)
  ) u_trk_p1 (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (p1_state),
    .hold    (hitstop),
    .landed  (hit_p2),
    .active  (p1_active)
  );

  hit_attack_tracker #(
    .ACT_START (ACT_START),
    .ACT_END   (ACT_END)
  ) u_trk_p2 (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (p2_state),
    .hold    (hitstop),
    .landed  (hit_p1),
    .active  (p2_active)
  );

  assign any_ko = p1_ko || p2_ko;

  // hit_pN means player N is the defender. Both can be true on the same
  // cycle, which is a trade.
  assign hit_p2 = p1_active && in_reach(p1_x, p2_x, SPAN) &&
                  (p2_state != ST_HITSTUN) && !any_ko && !hitstop;
  assign hit_p1 = p2_active && in_reach(p2_x, p1_x, SPAN) &&
                  (p1_state != ST_HITSTUN) && !any_ko && !hitstop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_got_hit <= 1'b0;
      p2_got_hit <= 1'b0;
      p1_health  <= HMAX;
      p2_health  <= HMAX;
      p1_ko      <= 1'b0;
      p2_ko      <= 1'b0;
    end else begin
      p1_got_hit <= hit_p1;
      p2_got_hit <= hit_p2;
      if (hit_p1) begin
        p1_health <= take_damage(p1_health);
        if (p1_health <= DMG)
          p1_ko <= 1'b1;
      end
      if (hit_p2) begin
        p2_health <= take_damage(p2_health);
        if (p2_health <= DMG)
          p2_ko <= 1'b1;
      end
    end
  end

`ifdef HITSTOP_EN
  localparam int HS_W = $clog2(HITSTOP_CYC + 1);

  logic [HS_W-1:0] hs_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      hs_cnt <= '0;
    else if (hit_p1 || hit_p2)
      hs_cnt <= HS_W'(HITSTOP_CYC);
    else if (hs_cnt != '0)
      hs_cnt <= hs_cnt - 1'b1;
  end

  assign hitstop = (hs_cnt != '0);
`else
  assign hitstop = 1'b0;
`endif

endmodule

// File: tb/tb_hit_resolver.sv
module tb_hit_resolver;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd2;
  localparam logic [2:0] S_HITSTUN = 3'd3;

  logic       clk;
  logic       reset_n;
  logic [9:0] p1_x;
  logic [2:0] p1_state;
  logic [9:0] p2_x;
  logic [2:0] p2_state;
  logic       p1_got_hit;
  logic       p2_got_hit;
  logic [6:0] p1_health;
  logic [6:0] p2_health;
  logic       p1_ko;
  logic       p2_ko;
  logic       hitstop;

  int errors = 0;
  int checks = 0;

  hit_resolver dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .p1_x       (p1_x),
    .p1_state   (p1_state),
    .p2_x       (p2_x),
    .p2_state   (p2_state),
    .p1_got_hit (p1_got_hit),
    .p2_got_hit (p2_got_hit),
    .p1_health  (p1_health),
    .p2_health  (p2_health),
    .p1_ko      (p1_ko),
    .p2_ko      (p2_ko),
    .hitstop    (hitstop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied before the call are the cycle-N inputs; outputs sampled
  // on return are the registered cycle-N+1 values.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    p1_state = S_IDLE;
    p2_state = S_IDLE;
    p1_x     = 10'd100;
    p2_x     = 10'd180;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++; if (p1_health !== 7'd100) begin errors++; $display("FAIL reset_p1_health: got %0d want 100", p1_health); end
    checks++; if (p2_health !== 7'd100) begin errors++; $display("FAIL reset_p2_health: got %0d want 100", p2_health); end
    checks++; if ({p1_ko, p2_ko} !== 2'b00) begin errors++; $display("FAIL reset_ko: got %b want 00", {p1_ko, p2_ko}); end
    checks++; if ({p1_got_hit, p2_got_hit} !== 2'b00) begin errors++; $display("FAIL reset_got_hit: got %b want 00", {p1_got_hit, p2_got_hit}); end
    checks++; if (hitstop !== 1'b0) begin errors++; $display("FAIL reset_hitstop: got %b want 0", hitstop); end
  endtask

  task automatic test_hit_lands();
    do_reset();
    p1_x = 10'd100;
    p2_x = 10'd180;
    for (int c = 0; c < 8; c++) begin
      p1_state = (c < 6) ? S_ATTACK : S_IDLE;
      step();
      checks++; if (p2_got_hit !== (c == 1)) begin errors++; $display("FAIL hit_p2_pulse c=%0d: got %b want %b", c, p2_got_hit, (c == 1)); end
      checks++; if (p1_got_hit !== 1'b0) begin errors++; $display("FAIL hit_p1_quiet c=%0d: got %b want 0", c, p1_got_hit); end
    end
    checks++; if (p2_health !== 7'd90) begin errors++; $display("FAIL hit_p2_health: got %0d want 90", p2_health); end
    checks++; if (p1_health !== 7'd100) begin errors++; $display("FAIL hit_p1_health: got %0d want 100", p1_health); end
  endtask

  task automatic test_reach_edge();
    // 100+64+24 = 188: 187 is the farthest hit, 200 misses, equal x never hits
    do_reset();
    p1_x = 10'd100;
    p2_x = 10'd187;
    for (int c = 0; c < 6; c++) begin
      p1_state = (c < 5) ? S_ATTACK : S_IDLE;
      step();
      checks++; if (p2_got_hit !== (c == 1)) begin errors++; $display("FAIL edge187_pulse c=%0d: got %b want %b", c, p2_got_hit, (c == 1)); end
    end
    do_reset();
    p1_x = 10'd100;
    p2_x = 10'd200;
    for (int c = 0; c < 8; c++) begin
      p1_state = (c < 6) ? S_ATTACK : S_IDLE;
      step();
      checks++; if (p2_got_hit !== 1'b0) begin errors++; $display("FAIL miss200_pulse c=%0d: got %b want 0", c, p2_got_hit); end
    end
    checks++; if (p2_health !== 7'd100) begin errors++; $display("FAIL miss200_health: got %0d want 100", p2_health); end
    do_reset();
    p1_x = 10'd300;
    p2_x = 10'd300;
    for (int c = 0; c < 6; c++) begin
      p1_state = (c < 5) ? S_ATTACK : S_IDLE;
      p2_state = (c < 5) ? S_ATTACK : S_IDLE;
      step();
      checks++; if ({p1_got_hit, p2_got_hit} !== 2'b00) begin errors++; $display("FAIL equal_x_pulse c=%0d: got %b want 00", c, {p1_got_hit, p2_got_hit}); end
    end
  endtask

  task automatic test_trade();
    do_reset();
    p1_x = 10'd100;
    p2_x = 10'd150;
    for (int c = 0; c < 8; c++) begin
      p1_state = (c < 6) ? S_ATTACK : S_IDLE;
      p2_state = (c < 6) ? S_ATTACK : S_IDLE;
      step();
      checks++; if (p1_got_hit !== (c == 1)) begin errors++; $display("FAIL trade_p1_pulse c=%0d: got %b want %b", c, p1_got_hit, (c == 1)); end
      checks++; if (p2_got_hit !== (c == 1)) begin errors++; $display("FAIL trade_p2_pulse c=%0d: got %b want %b", c, p2_got_hit, (c == 1)); end
    end
    checks++; if (p1_health !== 7'd90) begin errors++; $display("FAIL trade_p1_health: got %0d want 90", p1_health); end
    checks++; if (p2_health !== 7'd90) begin errors++; $display("FAIL trade_p2_health: got %0d want 90", p2_health); end
  endtask

  task automatic test_ko();
    logic [6:0] exp_h;
    int pulses;
    do_reset();
    p1_x = 10'd100;
    p2_x = 10'd180;
    for (int a = 0; a < 11; a++) begin
      pulses = 0;
      for (int c = 0; c < 7; c++) begin
        p1_state = (c < 5) ? S_ATTACK : S_IDLE;
        step();
        if (p2_got_hit === 1'b1) pulses++;
      end
      exp_h = (a < 10) ? 7'(90 - 10 * a) : 7'd0;
      checks++; if (pulses != ((a < 10) ? 1 : 0)) begin errors++; $display("FAIL ko_pulses a=%0d: got %0d want %0d", a, pulses, (a < 10) ? 1 : 0); end
      checks++; if (p2_health !== exp_h) begin errors++; $display("FAIL ko_health a=%0d: got %0d want %0d", a, p2_health, exp_h); end
      checks++; if (p2_ko !== (a >= 9)) begin errors++; $display("FAIL ko_flag a=%0d: got %b want %b", a, p2_ko, (a >= 9)); end
    end
    checks++; if (p1_health !== 7'd100 || p1_ko !== 1'b0) begin errors++; $display("FAIL ko_p1_untouched: got %0d/%b want 100/0", p1_health, p1_ko); end
  endtask

  task automatic test_hitstun();
    // defender in HITSTUN for frames 0..2, then IDLE on frame 3: the attack
    // must still land on frame 3, so no connected flag was set earlier
    do_reset();
    p1_x = 10'd100;
    p2_x = 10'd180;
    for (int c = 0; c < 7; c++) begin
      p1_state = (c < 6) ? S_ATTACK : S_IDLE;
      p2_state = (c < 3) ? S_HITSTUN : S_IDLE;
      step();
      checks++; if (p2_got_hit !== (c == 3)) begin errors++; $display("FAIL hitstun_pulse c=%0d: got %b want %b", c, p2_got_hit, (c == 3)); end
    end
    checks++; if (p2_health !== 7'd90) begin errors++; $display("FAIL hitstun_health: got %0d want 90", p2_health); end
  endtask

  task automatic test_hitstop();
    logic exp_hs;
    logic exp_p1;
    do_reset();
    p1_x = 10'd100;
    p2_x = 10'd180;
    for (int c = 0; c < 10; c++) begin
      p1_state = S_ATTACK;
      p2_state = (c >= 2) ? S_ATTACK : S_IDLE;
      step();
`ifdef HITSTOP_EN
      exp_hs = (c >= 1 && c <= 4);
      exp_p1 = (c == 7);
`else
      exp_hs = 1'b0;
      exp_p1 = (c == 3);
`endif
      checks++; if (hitstop !== exp_hs) begin errors++; $display("FAIL hitstop_flag c=%0d: got %b want %b", c, hitstop, exp_hs); end
      checks++; if (p2_got_hit !== (c == 1)) begin errors++; $display("FAIL hitstop_p2_pulse c=%0d: got %b want %b", c, p2_got_hit, (c == 1)); end
      checks++; if (p1_got_hit !== exp_p1) begin errors++; $display("FAIL hitstop_p1_pulse c=%0d: got %b want %b", c, p1_got_hit, exp_p1); end
    end
    checks++; if (p1_health !== 7'd90 || p2_health !== 7'd90) begin errors++; $display("FAIL hitstop_health: got %0d/%0d want 90/90", p1_health, p2_health); end
  endtask

  task automatic test_reset_mid_attack();
    do_reset();
    p1_x = 10'd100;
    p2_x = 10'd180;
    p1_state = S_ATTACK;
    step();
    #2;
    reset_n = 1'b0;
    #2;
    checks++; if (p2_got_hit !== 1'b0 || p2_health !== 7'd100) begin errors++; $display("FAIL midrst_async: got %b/%0d want 0/100", p2_got_hit, p2_health); end
    step();
    checks++; if (p2_got_hit !== 1'b0 || p2_health !== 7'd100) begin errors++; $display("FAIL midrst_held: got %b/%0d want 0/100", p2_got_hit, p2_health); end
    p1_state = S_IDLE;
    reset_n = 1'b1;
    step();
    checks++; if (p2_got_hit !== 1'b0 || p2_health !== 7'd100) begin errors++; $display("FAIL midrst_after: got %b/%0d want 0/100", p2_got_hit, p2_health); end
  endtask

  initial begin
    reset_n  = 1'b0;
    p1_x     = 10'd0;
    p2_x     = 10'd0;
    p1_state = S_IDLE;
    p2_state = S_IDLE;
    test_reset();
    test_hit_lands();
    test_reach_edge();
    test_trade();
    test_ko();
    test_hitstun();
    test_hitstop();
    test_reset_mid_attack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
